// File: rtl/nrf_spi_responder_if.sv
// nrf_spi_responder_if: SPI pin bundle between an nRF24L01-style master and the responder.
//   sck, csn, mosi : driven by the master (csn active low, mode 0)
//   miso           : driven by the responder, MSB first
//   miso_oe        : responder's board-level tristate enable for miso
interface nrf_spi_responder_if;
  logic sck;
  logic csn;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sck, output csn, output mosi, input miso, input miso_oe);
  modport slave  (input sck, input csn, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/nrf_spi_responder.sv
// nrf_spi_responder: SPI mode-0 slave emulating the nRF24L01 command interface.
// Oversamples the SPI pins on clk_50, decodes command bytes, holds a small register file
// and a loopback payload buffer (W_TX_PAYLOAD bytes come back via R_RX_PAYLOAD).
//
// Ports:
//   clk_50    system clock, rising edge
//   rst       synchronous active-high reset
//   spi       nrf_spi_responder_if.slave (sck/csn/mosi in, miso/miso_oe out)
//   cmd_valid 1-cycle pulse when a command byte completes
//   cmd_out   last completed command byte
//   rx_dr     STATUS bit 6, sticky
//   pl_count  bytes currently held in the payload buffer
//   irq_n     only when NRF_RESP_IRQ_EN is defined: registered ~rx_dr
//
// Build option: define NRF_RESP_IRQ_EN to add the irq_n output.
module nrf_spi_responder #(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned PAYLOAD_MAX = 32,
  parameter logic [7:0]  REG0_RESET  = 8'h08
) (
  input  logic                      clk_50,
  input  logic                      rst,
  nrf_spi_responder_if.slave        spi,
  output logic                      cmd_valid,
  output logic [7:0]                cmd_out,
  output logic                      rx_dr,
  output logic [5:0]                pl_count
`ifdef NRF_RESP_IRQ_EN
  ,
  output logic                      irq_n
`endif
);

  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned PW = (PAYLOAD_MAX > 1) ? $clog2(PAYLOAD_MAX) : 1;
  localparam logic [5:0] NumRegs6 = 6'(NUM_REGS);
  localparam logic [5:0] PlMax6   = 6'(PAYLOAD_MAX);

  localparam logic [7:0] CmdRRxPayload = 8'h61;
  localparam logic [7:0] CmdWTxPayload = 8'hA0;
  localparam logic [7:0] CmdFlushTx    = 8'hE1;
  localparam logic [7:0] CmdFlushRx    = 8'hE2;

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  state_e       state_q;
  logic [2:0]   sck_s, csn_s;
  logic [1:0]   mosi_s;
  logic [2:0]   bit_cnt_q;
  logic [6:0]   shift_in_q;   // first 7 bits of the byte in flight
  logic [6:0]   shift_out_q;  // bits still to send after the one on miso
  logic         miso_q, miso_oe_q;
  logic         cmd_valid_q;
  logic [7:0]   cmd_q;
  logic         rx_dr_q;
  logic         load_pend_q;  // a byte completed; next sck fall loads the next out byte
  logic         out_first_q;  // next load is out byte 1 of the frame
  logic         in_first_q;   // next completed data byte is the first of the frame
  logic [7:0]   regs_q [NUM_REGS];
  logic [7:0]   mem_q  [PAYLOAD_MAX];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [5:0]   count_q;

  // Edge detection on the synchronised pins: flop2 against flop3.
  logic sck_rise, sck_fall, csn_rise, csn_fall;
  assign sck_rise = sck_s[1] & ~sck_s[2];
  assign sck_fall = ~sck_s[1] & sck_s[2];
  assign csn_rise = csn_s[1] & ~csn_s[2];
  assign csn_fall = ~csn_s[1] & csn_s[2];

  logic [7:0] in_byte;
  assign in_byte = {shift_in_q, mosi_s[1]};

  logic empty, full;
  logic [7:0] status;
  logic [4:0] addr;
  assign empty  = (count_q == 6'd0);
  assign full   = (count_q == PlMax6);
  assign status = {1'b0, rx_dr_q, 2'b00, {3{empty}}, full};
  assign addr   = cmd_q[4:0];

  logic addr_in_range;
  assign addr_in_range = ({1'b0, addr} < NumRegs6);

  logic [7:0] reg_rd;
  always_comb begin
    reg_rd = 8'h00;
    if (addr == 5'd7) begin
      reg_rd = status;
    end else if (addr_in_range) begin
      reg_rd = regs_q[addr[AW-1:0]];
    end
  end

  // Sck activity only counts inside a frame and not on a csn edge cycle.
  logic frame_ok, byte_done, push_en, load_en, pop_en;
  assign frame_ok  = (state_q != StIdle) & ~csn_rise & ~csn_fall;
  assign byte_done = frame_ok & sck_rise & (bit_cnt_q == 3'd7);
  assign push_en   = byte_done & (state_q == StData) & (cmd_q == CmdWTxPayload) & ~full;
  assign load_en   = frame_ok & sck_fall & load_pend_q;
  assign pop_en    = load_en & (cmd_q == CmdRRxPayload) & ~empty;

  logic [7:0] next_out;
  always_comb begin
    next_out = 8'h00;
    if (cmd_q[7:5] == 3'b000 && out_first_q) begin
      next_out = reg_rd;
    end else if (pop_en) begin
      next_out = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk_50) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= in_byte;
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q     <= StIdle;
      // csn flops reset low so a csn already low at release is not seen as a fall.
      sck_s       <= 3'b000;
      csn_s       <= 3'b000;
      mosi_s      <= 2'b00;
      bit_cnt_q   <= 3'd0;
      shift_in_q  <= 7'd0;
      shift_out_q <= 7'd0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= 8'h00;
      rx_dr_q     <= 1'b0;
      load_pend_q <= 1'b0;
      out_first_q <= 1'b0;
      in_first_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 6'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == 0) ? REG0_RESET : 8'h00;
      end
    end else begin
      sck_s       <= {sck_s[1:0], spi.sck};
      csn_s       <= {csn_s[1:0], spi.csn};
      mosi_s      <= {mosi_s[0], spi.mosi};
      cmd_valid_q <= 1'b0;

      if (csn_rise) begin
        if (state_q != StIdle) begin
          if (state_q == StData && cmd_q == CmdWTxPayload && !empty) begin
            rx_dr_q <= 1'b1;
          end
          state_q     <= StIdle;
          miso_q      <= 1'b0;
          miso_oe_q   <= 1'b0;
          load_pend_q <= 1'b0;
        end
      end else if (csn_fall) begin
        state_q     <= StCmd;
        bit_cnt_q   <= 3'd0;
        shift_out_q <= status[6:0];
        miso_q      <= status[7];
        miso_oe_q   <= 1'b1;
        load_pend_q <= 1'b0;
      end else if (state_q != StIdle) begin
        if (sck_rise) begin
          shift_in_q <= in_byte[6:0];
          bit_cnt_q  <= bit_cnt_q + 3'd1;
          if (byte_done) begin
            load_pend_q <= 1'b1;
            if (state_q == StCmd) begin
              cmd_q       <= in_byte;
              cmd_valid_q <= 1'b1;
              state_q     <= StData;
              out_first_q <= 1'b1;
              in_first_q  <= 1'b1;
              if (in_byte == CmdFlushTx || in_byte == CmdFlushRx) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= 6'd0;
              end
            end else begin
              in_first_q <= 1'b0;
              if (cmd_q[7:5] == 3'b001 && in_first_q) begin
                if (addr == 5'd7) begin
                  // STATUS: write-1-to-clear on bit 6, rest read-only.
                  if (in_byte[6]) begin
                    rx_dr_q <= 1'b0;
                  end
                end else if (addr_in_range) begin
                  regs_q[addr[AW-1:0]] <= in_byte;
                end
              end
              if (push_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
                count_q  <= count_q + 6'd1;
              end
            end
          end
        end else if (sck_fall) begin
          if (load_en) begin
            load_pend_q <= 1'b0;
            out_first_q <= 1'b0;
            shift_out_q <= next_out[6:0];
            miso_q      <= next_out[7];
            if (pop_en) begin
              rd_ptr_q <= rd_ptr_q + PW'(1);
              count_q  <= count_q - 6'd1;
            end
          end else begin
            shift_out_q <= {shift_out_q[5:0], 1'b0};
            miso_q      <= shift_out_q[6];
          end
        end
      end
    end
  end

  assign spi.miso    = miso_q;
  assign spi.miso_oe = miso_oe_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_out     = cmd_q;
  assign rx_dr       = rx_dr_q;
  assign pl_count    = count_q;

`ifdef NRF_RESP_IRQ_EN
  logic irq_n_q;
  always_ff @(posedge clk_50) begin
    if (rst) begin
      irq_n_q <= 1'b1;
    end else begin
      irq_n_q <= ~rx_dr_q;
    end
  end
  assign irq_n = irq_n_q;
`endif

endmodule

// File: tb/tb_nrf_spi_responder.sv
// Bench for nrf_spi_responder: drives SPI frames and compares every miso byte and the
// status outputs against a queue-based model of the nRF command set.
module tb_nrf_spi_responder;
  localparam int Half = 4;  // clk_50 cycles per sck half period

  typedef logic [7:0] bq_t[$];

  logic clk_50 = 1'b0;
  logic rst;
  always #10 clk_50 = ~clk_50;

  nrf_spi_responder_if spi_if ();
  logic       cmd_valid;
  logic [7:0] cmd_out;
  logic       rx_dr;
  logic [5:0] pl_count;
`ifdef NRF_RESP_IRQ_EN
  logic       irq_n;
`endif

  nrf_spi_responder #(
    .NUM_REGS   (8),
    .PAYLOAD_MAX(32),
    .REG0_RESET (8'h08)
  ) dut (
    .clk_50   (clk_50),
    .rst      (rst),
    .spi      (spi_if),
    .cmd_valid(cmd_valid),
    .cmd_out  (cmd_out),
    .rx_dr    (rx_dr),
    .pl_count (pl_count)
`ifdef NRF_RESP_IRQ_EN
    ,
    .irq_n    (irq_n)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int exp_pulses = 0;

  always @(negedge clk_50) if (cmd_valid === 1'b1) pulses++;

  // Reference model
  logic [7:0] m_regs [8];
  logic       m_rx_dr;
  bq_t        m_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_regs[0] = 8'h08;
    m_rx_dr = 1'b0;
    m_q.delete();
  endfunction

  function automatic logic [7:0] m_status();
    logic e, f;
    e = (m_q.size() == 0);
    f = (m_q.size() == 32);
    return {1'b0, m_rx_dr, 2'b00, e, e, e, f};
  endfunction

  function automatic logic [7:0] m_reg_read(input logic [4:0] a);
    if (a == 5'd7) return m_status();
    if (a < 5'd8) return m_regs[a[2:0]];
    return 8'h00;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_if.mosi = tx[i];
      wait_clk(Half);
      rx[i] = spi_if.miso;
      spi_if.sck = 1'b1;
      wait_clk(Half);
      spi_if.sck = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_pl_count"}, 32'(pl_count), 32'(m_q.size()));
    check_eq({tag, "_rx_dr"}, 32'(rx_dr), 32'(m_rx_dr));
`ifdef NRF_RESP_IRQ_EN
    check_eq({tag, "_irq_n"}, 32'(irq_n), 32'(~m_rx_dr));
`endif
  endtask

  // Runs one frame of full bytes plus optional trailing partial bits; checks against the model.
  task automatic frame_check(input string tag, input bq_t tx, input int part_bits,
                             input logic [7:0] part_byte, output bq_t rx);
    bq_t exp;
    logic [7:0] cmd, out, b;
    cmd = tx[0];
    exp.push_back(m_status());
    if (cmd == 8'hE1 || cmd == 8'hE2) m_q.delete();
    for (int k = 1; k < tx.size(); k++) begin
      out = 8'h00;
      if (cmd[7:5] == 3'b000 && k == 1) out = m_reg_read(cmd[4:0]);
      else if (cmd == 8'h61 && m_q.size() > 0) out = m_q.pop_front();
      exp.push_back(out);
      if (cmd[7:5] == 3'b001 && k == 1) begin
        if (cmd[4:0] == 5'd7) begin
          if (tx[k][6]) m_rx_dr = 1'b0;
        end else if (cmd[4:0] < 5'd8) begin
          m_regs[cmd[2:0]] = tx[k];
        end
      end
      if (cmd == 8'hA0 && m_q.size() < 32) m_q.push_back(tx[k]);
    end
    // The load that follows the last complete byte still pops.
    if (cmd == 8'h61 && m_q.size() > 0) void'(m_q.pop_front());
    if (cmd == 8'hA0 && m_q.size() > 0) m_rx_dr = 1'b1;
    exp_pulses++;

    rx = {};
    spi_if.csn = 1'b0;
    wait_clk(Half);
    check_eq({tag, "_oe_on"}, 32'(spi_if.miso_oe), 32'd1);
    foreach (tx[k]) begin
      spi_byte(tx[k], 8, b);
      rx.push_back(b);
    end
    if (part_bits > 0) spi_byte(part_byte, part_bits, b);
    wait_clk(Half);
    spi_if.csn = 1'b1;
    wait_clk(Half);
    check_eq({tag, "_oe_off"}, 32'(spi_if.miso_oe), 32'd0);
    for (int k = 0; k < tx.size(); k++) begin
      check_eq($sformatf("%s_miso%0d", tag, k), 32'(rx[k]), 32'(exp[k]));
    end
    check_eq({tag, "_cmd_out"}, 32'(cmd_out), 32'(cmd));
    check_eq({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
    check_outputs(tag);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_miso"}, 32'(spi_if.miso), 32'd0);
    check_eq({tag, "_miso_oe"}, 32'(spi_if.miso_oe), 32'd0);
    check_eq({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check_eq({tag, "_cmd_out"}, 32'(cmd_out), 32'd0);
    check_outputs(tag);
  endtask

  initial begin
    bq_t tx, rx;
    logic [7:0] b, cmd;
    int len, sel;

    spi_if.sck  = 1'b0;
    spi_if.csn  = 1'b1;
    spi_if.mosi = 1'b0;
    rst = 1'b1;
    m_reset();
    @(negedge clk_50);
    wait_clk(4);
    check_reset_state("reset");
    rst = 1'b0;
    wait_clk(4);

    tx = {8'hFF, 8'h00};
    frame_check("nop", tx, 0, 8'h00, rx);
    check_eq("nop_status_lit", 32'(rx[0]), 32'h0E);
    check_eq("nop_b1_lit", 32'(rx[1]), 32'h00);

    tx = {8'h00, 8'h00};
    frame_check("rd_reg0", tx, 0, 8'h00, rx);
    check_eq("rd_reg0_lit", 32'(rx[1]), 32'h08);

    tx = {8'h25, 8'h5A};
    frame_check("wr_reg5", tx, 0, 8'h00, rx);
    tx = {8'h05, 8'h00};
    frame_check("rd_reg5", tx, 0, 8'h00, rx);
    check_eq("rd_reg5_lit", 32'(rx[1]), 32'h5A);

    tx = {8'hA0, 8'h11, 8'h22, 8'h33};
    frame_check("push3", tx, 0, 8'h00, rx);
    check_eq("push3_count_lit", 32'(pl_count), 32'd3);
    check_eq("push3_rx_dr_lit", 32'(rx_dr), 32'd1);
    tx = {8'hFF};
    frame_check("st_after_push", tx, 0, 8'h00, rx);
    check_eq("st_after_push_lit", 32'(rx[0]), 32'h40);
    tx = {8'h61, 8'h00, 8'h00, 8'h00};
    frame_check("pop3", tx, 0, 8'h00, rx);
    check_eq("pop3_lit1", 32'(rx[1]), 32'h11);
    check_eq("pop3_lit2", 32'(rx[2]), 32'h22);
    check_eq("pop3_lit3", 32'(rx[3]), 32'h33);

    tx = {8'hA0};
    repeat (33) tx.push_back(8'($urandom));
    frame_check("push33", tx, 0, 8'h00, rx);
    check_eq("push33_count_lit", 32'(pl_count), 32'd32);
    tx = {8'hFF};
    frame_check("st_full", tx, 0, 8'h00, rx);
    check_eq("st_full_lit", 32'(rx[0]), 32'h41);
    tx = {8'hE1};
    frame_check("flush", tx, 0, 8'h00, rx);
    check_eq("flush_count_lit", 32'(pl_count), 32'd0);
    tx = {8'hFF};
    frame_check("st_flushed", tx, 0, 8'h00, rx);
    check_eq("st_flushed_lit", 32'(rx[0]), 32'h4E);

    tx = {8'h27};
    frame_check("partial", tx, 5, 8'h40, rx);
    check_eq("partial_rx_dr_lit", 32'(rx_dr), 32'd1);
    tx = {8'h27, 8'h40};
    frame_check("clr_rx_dr", tx, 0, 8'h00, rx);
    check_eq("clr_rx_dr_lit", 32'(rx_dr), 32'd0);

    for (int f = 0; f < 40; f++) begin
      sel = $urandom_range(0, 7);
      len = $urandom_range(1, 4);
      case (sel)
        0: cmd = {3'b000, 5'($urandom_range(0, 31))};
        1: cmd = {3'b001, 5'($urandom_range(0, 9))};
        2: cmd = 8'h61;
        3: begin cmd = 8'hA0; len = $urandom_range(1, 8); end
        4: cmd = ($urandom_range(0, 1) == 0) ? 8'hE1 : 8'hE2;
        5: cmd = 8'hFF;
        6: cmd = 8'($urandom);
        default: cmd = 8'h27;
      endcase
      tx = {cmd};
      for (int k = 1; k < len; k++) tx.push_back(8'($urandom));
      frame_check($sformatf("rnd%0d", f), tx, 0, 8'h00, rx);
    end

    // Reset in the middle of an R_RX_PAYLOAD frame with csn held low.
    tx = {8'hA0, 8'h01, 8'h02, 8'h03};
    frame_check("refill", tx, 0, 8'h00, rx);
    spi_if.csn = 1'b0;
    wait_clk(Half);
    spi_byte(8'h61, 8, b);
    exp_pulses++;
    spi_byte(8'h00, 3, b);
    rst = 1'b1;
    wait_clk(3);
    m_reset();
    check_reset_state("rst_mid");
    rst = 1'b0;
    spi_byte(8'h25, 8, b);
    spi_byte(8'h77, 8, b);
    wait_clk(Half);
    check_eq("ignored_oe", 32'(spi_if.miso_oe), 32'd0);
    check_eq("ignored_cmd_out", 32'(cmd_out), 32'd0);
    check_eq("ignored_pulses", 32'(pulses), 32'(exp_pulses));
    spi_if.csn = 1'b1;
    wait_clk(Half);
    tx = {8'h05, 8'h00};
    frame_check("post_rst_reg5", tx, 0, 8'h00, rx);
    check_eq("post_rst_reg5_lit", 32'(rx[1]), 32'h00);
    tx = {8'h00, 8'h00};
    frame_check("post_rst_reg0", tx, 0, 8'h00, rx);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
